// File: rtl/pps_monitor.sv
// -----------------------------------------------------------------------------
// pps_monitor
//
// Measures an external pulse-per-second input against the local clock and
// reports its health over a Wishbone slave port. The PPS is resynchronised,
// the interval between rising edges is counted in clock cycles, and each
// interval is classified against a programmable nominal period and tolerance.
// A small FSM (IDLE/ACQ/TRACK/LOCKED/LOST) tracks lock, missed pulses and
// out-of-tolerance periods.
//
// Optional feature:
//   PPS_MINMAX_EN  - when defined, min/max period tracking is compiled in
//                    (addresses 3/4). When undefined, those addresses read 0
//                    and writes to them have no effect.
//
// Ports:
//   i_clk          system clock (only clock)
//   i_reset        asynchronous active-high reset
//   i_pps          external PPS, asynchronous to i_clk
//   i_wb_cyc_stb   Wishbone cycle+strobe
//   i_wb_we        Wishbone write enable
//   i_wb_addr      register address (3 bits)
//   i_wb_data      write data
//   o_wb_ack       acknowledge, one cycle after each request
//   o_wb_stall     always 0
//   o_wb_data      registered read data, valid with o_wb_ack
//   o_locked       high while the FSM is in LOCKED
//   o_int          sticky event flag, cleared by a read of address 7
//
// Register map:
//   0 nominal (RW)     1 tolerance (RW)    2 last_period (RO)
//   3 min_period       4 max_period        (any write to 3/4 resets min/max)
//   5 miss_cnt (write clears)              6 bad_cnt (write clears)
//   7 status {26'h0, o_int, o_locked, 1'b0, state[2:0]} (read clears o_int)
//
// FSM state is externally visible through status register bits [2:0].
// -----------------------------------------------------------------------------
module pps_monitor #(
  parameter logic [31:0] CLOCK_FREQUENCY_HZ = 32'd100_000_000,
  parameter logic [31:0] DEFAULT_TOLERANCE  = 32'd1000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pps,
  input  logic        i_wb_cyc_stb,
  input  logic        i_wb_we,
  input  logic [2:0]  i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        o_locked,
  output logic        o_int
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACQ    = 3'd1,
    ST_TRACK  = 3'd2,
    ST_LOCKED = 3'd3,
    ST_LOST   = 3'd4
  } state_t;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // ---------------------------------------------------------------------------
  // PPS synchroniser and registered rising-edge detector.
  // i_pps rise -> meta (1) -> sync (2) -> edge_q (3 cycles).
  // ---------------------------------------------------------------------------
  logic pps_meta_q, pps_sync_q, pps_dly_q, edge_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pps_meta_q <= 1'b0;
      pps_sync_q <= 1'b0;
      pps_dly_q  <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      pps_meta_q <= i_pps;
      pps_sync_q <= pps_meta_q;
      pps_dly_q  <= pps_sync_q;
      edge_q     <= pps_sync_q & ~pps_dly_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [31:0] ctr_q, ctr_d;
  logic [31:0] nominal_q, nominal_d;
  logic [31:0] tol_q, tol_d;
  logic [31:0] last_q, last_d;
  logic [31:0] miss_q, miss_d;
  logic [31:0] bad_q, bad_d;
  logic        int_q, int_d;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] min_rd, max_rd;

  // ---------------------------------------------------------------------------
  // Period measurement and classification
  // ---------------------------------------------------------------------------
  logic [31:0]        period;
  logic signed [32:0] diff;
  logic [32:0]        abs_diff;
  logic [32:0]        limit;
  logic               good;
  logic               timeout;

  always_comb begin
    // r_ctr counts cycles since the last edge pulse, so the interval is r_ctr+1.
    // Clamp so a saturated counter does not wrap to a tiny period.
    period   = (ctr_q == ALL_ONES) ? ALL_ONES : ctr_q + 32'd1;
    diff     = $signed({1'b0, period}) - $signed({1'b0, nominal_q});
    abs_diff = diff[32] ? 33'(-diff) : 33'(diff);
    good     = abs_diff <= {1'b0, tol_q};
    limit    = {1'b0, nominal_q} + {1'b0, tol_q};
    // >= rather than == so that lowering nominal/tolerance mid-interval
    // cannot let the counter step past the limit unnoticed.
    timeout  = {1'b0, ctr_q} >= limit;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and event generation
  // ---------------------------------------------------------------------------
  logic meas;      // edge measured in ACQ/TRACK/LOCKED
  logic bad_evt;
  logic miss_evt;
  logic int_set;

  always_comb begin
    state_d  = state_q;
    meas     = 1'b0;
    bad_evt  = 1'b0;
    miss_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (edge_q) state_d = ST_ACQ;
      end
      ST_ACQ, ST_TRACK, ST_LOCKED: begin
        if (edge_q) begin
          meas = 1'b1;
          if (good) begin
            state_d = (state_q == ST_ACQ) ? ST_TRACK : ST_LOCKED;
          end else begin
            state_d = ST_ACQ;
            bad_evt = 1'b1;
          end
        end else if (timeout) begin
          state_d  = ST_LOST;
          miss_evt = 1'b1;
        end
      end
      ST_LOST: begin
        // The edge ending a lost interval is not a meaningful period.
        if (edge_q) state_d = ST_ACQ;
      end
      default: state_d = ST_IDLE;
    endcase
    int_set = miss_evt | bad_evt |
              ((state_q == ST_LOCKED) != (state_d == ST_LOCKED));
  end

  // ---------------------------------------------------------------------------
  // Wishbone: a request is any cycle with i_wb_cyc_stb high. The slave never
  // stalls, so every request is accepted the cycle it is presented and is
  // answered by o_wb_ack exactly one cycle later, with o_wb_data valid in that
  // same ack cycle. Back-to-back requests therefore give back-to-back acks.
  // ---------------------------------------------------------------------------
  logic wr, rd;
  assign wr = i_wb_cyc_stb & i_wb_we;
  assign rd = i_wb_cyc_stb & ~i_wb_we;

  always_comb begin
    nominal_d = nominal_q;
    tol_d     = tol_q;
    if (wr && i_wb_addr == 3'd0) nominal_d = i_wb_data;
    if (wr && i_wb_addr == 3'd1) tol_d     = i_wb_data;

    ctr_d = edge_q ? 32'd0 : ((ctr_q == ALL_ONES) ? ctr_q : ctr_q + 32'd1);

    last_d = meas ? period : last_q;

    // A clear coincident with an increment leaves the counter at 1.
    miss_d = miss_q;
    if (wr && i_wb_addr == 3'd5) miss_d = miss_evt ? 32'd1 : 32'd0;
    else if (miss_evt && miss_q != ALL_ONES) miss_d = miss_q + 32'd1;

    bad_d = bad_q;
    if (wr && i_wb_addr == 3'd6) bad_d = bad_evt ? 32'd1 : 32'd0;
    else if (bad_evt && bad_q != ALL_ONES) bad_d = bad_q + 32'd1;

    // A new event wins over a simultaneous read-clear.
    int_d = int_q;
    if (int_set) int_d = 1'b1;
    else if (rd && i_wb_addr == 3'd7) int_d = 1'b0;

    rdata_d = rdata_q;
    if (rd) begin
      case (i_wb_addr)
        3'd0:    rdata_d = nominal_q;
        3'd1:    rdata_d = tol_q;
        3'd2:    rdata_d = last_q;
        3'd3:    rdata_d = min_rd;
        3'd4:    rdata_d = max_rd;
        3'd5:    rdata_d = miss_q;
        3'd6:    rdata_d = bad_q;
        default: rdata_d = {26'h0, int_q, o_locked, 1'b0, state_q};
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      ctr_q     <= 32'd0;
      nominal_q <= CLOCK_FREQUENCY_HZ;
      tol_q     <= DEFAULT_TOLERANCE;
      last_q    <= 32'd0;
      miss_q    <= 32'd0;
      bad_q     <= 32'd0;
      int_q     <= 1'b0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      nominal_q <= nominal_d;
      tol_q     <= tol_d;
      last_q    <= last_d;
      miss_q    <= miss_d;
      bad_q     <= bad_d;
      int_q     <= int_d;
      ack_q     <= i_wb_cyc_stb;
      rdata_q   <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional min/max period tracking
  // ---------------------------------------------------------------------------
`ifdef PPS_MINMAX_EN
  logic [31:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (wr && (i_wb_addr == 3'd3 || i_wb_addr == 3'd4)) begin
      min_d = ALL_ONES;
      max_d = 32'd0;
    end
    // Applied after the reset so a same-cycle period is not lost.
    if (meas && (state_q == ST_TRACK || state_q == ST_LOCKED)) begin
      if (period < min_d) min_d = period;
      if (period > max_d) max_d = period;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      min_q <= ALL_ONES;
      max_q <= 32'd0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_rd = min_q;
  assign max_rd = max_q;
`else
  assign min_rd = 32'd0;
  assign max_rd = 32'd0;
`endif

  assign o_wb_ack   = ack_q;
  assign o_wb_stall = 1'b0;
  assign o_wb_data  = rdata_q;
  assign o_locked   = (state_q == ST_LOCKED);
  assign o_int      = int_q;

endmodule
